// File: rtl/req2send_pkg.sv
// Types and helpers shared by the req2send receive stage, its FIFO and the bench.
package req2send_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACKD = 1'b1
    } rcv_state_e;

    localparam int DATA_W_DEF = 8;

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/req2send_fifo.sv
// Synchronous FIFO. The level is tracked separately, so the pointers wrap at DEPTH.
module req2send_fifo
    import req2send_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 4,
    localparam int LVL_W  = level_w(DEPTH),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [LVL_W-1:0]  o_level
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // An empty FIFO presents zero, so the head is zero straight out of reset.
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/req2send_rcv.sv
// Receive side of the req2send 4-phase handshake. Accepted words are buffered in a FIFO
// and re-presented on a valid/ready stream. ack stays low while the FIFO is full.
module req2send_rcv
    import req2send_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 4,
    parameter  int CNT_W  = 16,
    localparam int LVL_W  = level_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              request,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              proto_err
);

    rcv_state_e        r_state;
    rcv_state_e        w_state_nxt;
    logic              w_accept;
    logic              w_data_err;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_xfer_cnt;
    logic              r_proto_err;

    req2send_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_din   (data_in),
        .i_pop   (out_ready),
        .o_head  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Full comes from the registered level: a pop in the same cycle never frees a slot early.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (request && !w_full) w_state_nxt = ACKD;
            ACKD:    if (!request)           w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == IDLE) && request && !w_full;
        w_data_err = (r_state == ACKD) && request && (data_in != r_hold);
        ack        = (r_state == ACKD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_xfer_cnt  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold     <= data_in;
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
            if (w_data_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign out_valid  = !w_empty;
    assign xfer_count = r_xfer_cnt;
    assign proto_err  = r_proto_err;

`ifndef SYNTHESIS
    a_ack_rise: assert property (@(posedge clk) disable iff (reset)
        $rose(ack) |-> $past(r_state == IDLE && request));
    a_ack_fall: assert property (@(posedge clk) disable iff (reset)
        $fell(ack) |-> $past(!request));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        w_full |-> !w_accept);
    a_err_sticky: assert property (@(posedge clk) disable iff (reset)
        !$fell(proto_err));
`endif

endmodule

// File: tb/tb_req2send_rcv.sv
// Bench for req2send_rcv: directed handshake scenarios plus a randomized run
// compared against a queue-based model of the receive stage.
module tb_req2send_rcv;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          request;
    logic [DW-1:0] data_in;
    logic          ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fifo_level;
    logic [CW-1:0] xfer_count;
    logic          proto_err;

    int total = 0;
    int bad   = 0;

    req2send_rcv #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .data_in    (data_in),
        .ack        (ack),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .xfer_count (xfer_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset     = 1'b1;
        request   = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Full 4-phase transfer from the sender side; ok=0 if ack never rose or never fell.
    task automatic send(input logic [DW-1:0] d, output bit ok);
        int n;
        request = 1'b1;
        data_in = d;
        n = 0;
        @(negedge clk);
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = ack;
        request = 1'b0;
        @(negedge clk);
        n = 0;
        while (ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ack) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        request   = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b0)        begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00)  begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", xfer_count); end
        total++; if (proto_err !== 1'b0)  begin bad++; $display("FAIL rst_err got=%b exp=0", proto_err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        request   = 1'b1;
        data_in   = 8'hA5;
        @(negedge clk);
        total++; if (ack !== 1'b1)        begin bad++; $display("FAIL single_ack got=%b exp=1", ack); end
        total++; if (out_valid !== 1'b1)  begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hA5)  begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
        total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", xfer_count); end
        request = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b0)        begin bad++; $display("FAIL single_ack_low got=%b exp=0", ack); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL single_valid_1cyc got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [DW-1:0] got[$];
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), ok);
            total++; if (!ok) begin bad++; $display("FAIL bp_send%0d got=noack exp=ack", i); end
        end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
        request = 1'b1;
        data_in = 8'h05;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ack !== 1'b0) begin bad++; $display("FAIL bp_full_ack got=%b exp=0", ack); end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) got.push_back(out_data);
            if (ack) request = 1'b0;
            @(negedge clk);
        end
        request = 1'b0;
        total++; if (got.size() != 5) begin bad++; $display("FAIL bp_count_out got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            total++;
            if (got[i] !== DW'(i + 1)) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], i + 1); end
        end
        total++; if (xfer_count !== 4'd5) begin bad++; $display("FAIL bp_xfer got=%0d exp=5", xfer_count); end
    endtask

    task automatic test_full_pop_accept();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) send(8'h40 + DW'(i), ok);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fp_level0 got=%0d exp=4", fifo_level); end
        request   = 1'b1;
        data_in   = 8'h77;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL fp_level1 got=%0d exp=3", fifo_level); end
        total++; if (ack !== 1'b0)        begin bad++; $display("FAIL fp_no_bypass got=%b exp=0", ack); end
        @(negedge clk);
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fp_level2 got=%0d exp=4", fifo_level); end
        total++; if (ack !== 1'b1)        begin bad++; $display("FAIL fp_accept got=%b exp=1", ack); end
        request = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_proto_err();
        do_reset();
        request = 1'b1;
        data_in = 8'h3C;
        @(negedge clk);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL pe_ack got=%b exp=1", ack); end
        data_in = 8'h3D;
        @(negedge clk);
        total++; if (proto_err !== 1'b1)  begin bad++; $display("FAIL pe_set got=%b exp=1", proto_err); end
        total++; if (out_data !== 8'h3C)  begin bad++; $display("FAIL pe_data got=%h exp=3c", out_data); end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL pe_level got=%0d exp=1", fifo_level); end
        request = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL pe_sticky got=%b exp=1", proto_err); end
        do_reset();
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL pe_clear got=%b exp=0", proto_err); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        send(8'h11, ok);
        request = 1'b1;
        data_in = 8'h22;
        @(negedge clk);
        total++; if (ack !== 1'b1 || fifo_level !== 3'd2) begin
            bad++; $display("FAIL rm_pre got=ack%b/lvl%0d exp=ack1/lvl2", ack, fifo_level);
        end
        #1 reset = 1'b1;
        #1;
        total++; if (ack !== 1'b0)        begin bad++; $display("FAIL rm_ack got=%b exp=0", ack); end
        total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rm_level got=%0d exp=0", fifo_level); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", xfer_count); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b1)        begin bad++; $display("FAIL rm_reaccept got=%b exp=1", ack); end
        total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL rm_count1 got=%0d exp=1", xfer_count); end
        total++; if (out_data !== 8'h22 || fifo_level !== 3'd1) begin
            bad++; $display("FAIL rm_data got=%h/lvl%0d exp=22/lvl1", out_data, fifo_level);
        end
        request = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            send(DW'($urandom), ok);
            if (i == 16) begin
                total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL wrap16 got=%0d exp=0", xfer_count); end
            end
        end
        total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL wrap17 got=%0d exp=1", xfer_count); end
    endtask

    // Model: the FIFO is a queue, the sender side is a single "acknowledged" flag.
    task automatic test_random();
        logic [DW-1:0] q[$];
        bit  m_ack;
        int  m_cnt;
        bit  pop, acc, ack_n;
        do_reset();
        m_ack = 0;
        m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            total++; if (ack !== m_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, ack, m_ack); end
            total++; if (out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() != 0);
            end
            total++; if (fifo_level !== 3'(q.size())) begin
                bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, q.size());
            end
            total++; if (xfer_count !== CW'(m_cnt)) begin
                bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, xfer_count, m_cnt % 16);
            end
            if (q.size() != 0) begin
                total++; if (out_data !== q[0]) begin
                    bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, q[0]);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (request && m_ack && $urandom_range(0, 3) != 0) begin
                request = 1'b0;
            end else if (!request && !m_ack && $urandom_range(0, 2) == 0) begin
                request = 1'b1;
                data_in = DW'($urandom);
            end
            pop   = (q.size() != 0) && out_ready;
            acc   = !m_ack && request && (q.size() < DEPTH);
            ack_n = m_ack ? request : acc;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(data_in);
                m_cnt++;
            end
            m_ack = ack_n;
            @(negedge clk);
        end
        request = 1'b0;
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop_accept();
        test_proto_err();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
